// File: rtl/scoreboard_ctrl_pkg.sv
// Shared types and constants for the pending-write scoreboard controller.
package scoreboard_ctrl_pkg;
  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MDU_WAIT = 1'b1
  } sb_state_e;

  localparam int REG_X0    = 0;
  localparam int CNT_W_DEF = 2;
endpackage

// File: rtl/sb_counter_bank.sv
// Per-register pending-write counters: one increment port, one decrement port,
// two count read ports and a full flag for the ID destination.
module sb_counter_bank
  import scoreboard_ctrl_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int CNT_W = CNT_W_DEF,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_en,
  input  logic [AW-1:0]    inc_idx,
  input  logic             dec_en,
  input  logic [AW-1:0]    dec_idx,
  input  logic [AW-1:0]    rd_a_idx,
  input  logic [AW-1:0]    rd_b_idx,
  input  logic [AW-1:0]    full_idx,
  output logic [CNT_W-1:0] rd_a_cnt,
  output logic [CNT_W-1:0] rd_b_cnt,
  output logic             full,
  output logic             underflow
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NREGS-1:0][CNT_W-1:0] cnt;
  logic [NREGS-1:0]            inc_vec, dec_vec;

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (inc_en) inc_vec[inc_idx] = 1'b1;
    if (dec_en) dec_vec[dec_idx] = 1'b1;
  end

  // Entry REG_X0 is only ever written by reset, so it reads as zero forever.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      for (int r = REG_X0 + 1; r < NREGS; r++) begin
        if (inc_vec[r] && !dec_vec[r] && cnt[r] != CNT_MAX)
          cnt[r] <= cnt[r] + 1'b1;
        else if (dec_vec[r] && !inc_vec[r] && cnt[r] != '0)
          cnt[r] <= cnt[r] - 1'b1;
      end
    end
  end

  assign rd_a_cnt  = cnt[rd_a_idx];
  assign rd_b_cnt  = cnt[rd_b_idx];
  assign full      = (cnt[full_idx] == CNT_MAX);
  // A retire with nothing pending means WB saw a write that never issued.
  assign underflow = dec_en && (cnt[dec_idx] == '0);
endmodule

// File: rtl/scoreboard_ctrl.sv
// Pipeline sequencing controller: scoreboard RAW/WAW-capacity stalls,
// EX redirect flushes and MDU start/done sequencing.
module scoreboard_ctrl
  import scoreboard_ctrl_pkg::*;
#(
  parameter int NREGS       = 32,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int MDU_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] rs1_id,
  input  logic [4:0] rs2_id,
  input  logic [4:0] rd_id,
  input  logic       regwrite_id,
  input  logic       mdu_op_id,
  input  logic       redirect_ex,
  input  logic       wb_valid,
  input  logic [4:0] rd_wb,
  input  logic       regwrite_wb,
  input  logic       mdu_done,
  output logic       stall_if,
  output logic       stall_id,
  output logic       bubble_ex,
  output logic       stall_ex,
  output logic       flush_if,
  output logic       flush_id,
  output logic       mdu_start,
  output logic       sb_err
);
  localparam int            TW      = $clog2(MDU_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(MDU_TIMEOUT);
  localparam logic [4:0]    X0      = 5'(REG_X0);

  sb_state_e        state, state_nxt;
  logic [TW-1:0]    tmo, tmo_nxt;
  logic             sb_err_q, err_set;
  logic [CNT_W-1:0] rs1_cnt, rs2_cnt;
  logic             rd_full, underflow;
  logic             hazard, issue, inc_en, dec_en;
  logic             stall_if_c, stall_id_c, bubble_ex_c, stall_ex_c;
  logic             flush_if_c, flush_id_c, mdu_start_c;

  // Stored counts only: a same-cycle retire does not release the hazard
  // because the regfile is not write-through.
  assign hazard = id_valid &&
                  ((rs1_id != X0 && rs1_cnt != '0) ||
                   (rs2_id != X0 && rs2_cnt != '0) ||
                   (regwrite_id && rd_id != X0 && rd_full));
  assign issue  = id_valid && state == ST_RUN && !hazard && !redirect_ex;
  assign inc_en = issue && regwrite_id && rd_id != X0;
  assign dec_en = wb_valid && regwrite_wb && rd_wb != X0;

  sb_counter_bank #(.NREGS(NREGS), .CNT_W(CNT_W), .AW(5)) u_bank (
    .clk       (clk),
    .rst       (rst),
    .inc_en    (inc_en),
    .inc_idx   (rd_id),
    .dec_en    (dec_en),
    .dec_idx   (rd_wb),
    .rd_a_idx  (rs1_id),
    .rd_b_idx  (rs2_id),
    .full_idx  (rd_id),
    .rd_a_cnt  (rs1_cnt),
    .rd_b_cnt  (rs2_cnt),
    .full      (rd_full),
    .underflow (underflow)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_RUN;
      tmo      <= '0;
      sb_err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      tmo   <= tmo_nxt;
      if (err_set) sb_err_q <= 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    tmo_nxt     = tmo;
    err_set     = underflow;
    stall_if_c  = 1'b0;
    stall_id_c  = 1'b0;
    bubble_ex_c = 1'b0;
    stall_ex_c  = 1'b0;
    flush_if_c  = 1'b0;
    flush_id_c  = 1'b0;
    mdu_start_c = 1'b0;
    case (state)
      ST_RUN: begin
        if (mdu_done) err_set = 1'b1;
        if (redirect_ex) begin
          flush_if_c = 1'b1;
          flush_id_c = 1'b1;
        end else if (hazard) begin
          stall_if_c  = 1'b1;
          stall_id_c  = 1'b1;
          bubble_ex_c = 1'b1;
        end else if (issue && mdu_op_id) begin
          mdu_start_c = 1'b1;
          state_nxt   = ST_MDU_WAIT;
        end
      end
      ST_MDU_WAIT: begin
        // EX holds the MDU op, so a redirect cannot be resolved here.
        stall_if_c = 1'b1;
        stall_id_c = 1'b1;
        stall_ex_c = 1'b1;
        if (mdu_done) begin
          state_nxt = ST_RUN;
          tmo_nxt   = '0;
        end else if (tmo != TMO_MAX) begin
          tmo_nxt = tmo + 1'b1;
          if (tmo_nxt == TMO_MAX) err_set = 1'b1;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  assign stall_if  = !rst && stall_if_c;
  assign stall_id  = !rst && stall_id_c;
  assign bubble_ex = !rst && bubble_ex_c;
  assign stall_ex  = !rst && stall_ex_c;
  assign flush_if  = !rst && flush_if_c;
  assign flush_id  = !rst && flush_id_c;
  assign mdu_start = !rst && mdu_start_c;
  assign sb_err    = !rst && sb_err_q;
endmodule

// File: tb/tb_scoreboard_ctrl.sv
// Directed table, hand sequences and randomized run against a pending-count model.
module tb_scoreboard_ctrl;
  logic       clk, rst;
  logic       id_valid, regwrite_id, mdu_op_id, redirect_ex;
  logic [4:0] rs1_id, rs2_id, rd_id, rd_wb;
  logic       wb_valid, regwrite_wb, mdu_done;
  logic       stall_if, stall_id, bubble_ex, stall_ex;
  logic       flush_if, flush_id, mdu_start, sb_err;
  logic [7:0] outs;

  scoreboard_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rd_id(rd_id), .regwrite_id(regwrite_id), .mdu_op_id(mdu_op_id),
    .redirect_ex(redirect_ex), .wb_valid(wb_valid), .rd_wb(rd_wb),
    .regwrite_wb(regwrite_wb), .mdu_done(mdu_done), .stall_if(stall_if),
    .stall_id(stall_id), .bubble_ex(bubble_ex), .stall_ex(stall_ex),
    .flush_if(flush_if), .flush_id(flush_id), .mdu_start(mdu_start), .sb_err(sb_err)
  );

  assign outs = {stall_if, stall_id, bubble_ex, stall_ex, flush_if, flush_id, mdu_start, sb_err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       iv;
    logic [4:0] rs1, rs2, rd;
    logic       rw, mop, redir, wv;
    logic [4:0] rdwb;
    logic       rwwb, done;
  } in_t;

  typedef struct {
    in_t        i;
    logic [7:0] exp;
    string      nm;
  } vec_t;

  localparam logic [7:0] OK  = 8'h00;
  localparam logic [7:0] HAZ = 8'hE0;
  localparam logic [7:0] WT  = 8'hD0;
  localparam logic [7:0] FL  = 8'h0C;
  localparam logic [7:0] ST  = 8'h02;
  localparam logic [7:0] ER  = 8'h01;
  localparam int         N   = -1;

  int   n_vec = 0;
  int   n_bad = 0;
  vec_t tbl[$];

  function automatic in_t mk(int iv, int rs1, int rs2, int rd, int rw, int mop,
                             int redir, int wb, int done);
    in_t t;
    t.iv = iv[0]; t.rs1 = 5'(rs1); t.rs2 = 5'(rs2); t.rd = 5'(rd);
    t.rw = rw[0]; t.mop = mop[0]; t.redir = redir[0];
    t.wv = (wb >= 0); t.rwwb = (wb >= 0); t.rdwb = (wb >= 0) ? 5'(wb) : 5'd0;
    t.done = done[0];
    return t;
  endfunction

  function automatic void add(input in_t i, input logic [7:0] e, input string nm);
    vec_t v;
    v.i = i; v.exp = e; v.nm = nm;
    tbl.push_back(v);
  endfunction

  task automatic apply(input in_t i);
    id_valid = i.iv; rs1_id = i.rs1; rs2_id = i.rs2; rd_id = i.rd;
    regwrite_id = i.rw; mdu_op_id = i.mop; redirect_ex = i.redir;
    wb_valid = i.wv; rd_wb = i.rdwb; regwrite_wb = i.rwwb; mdu_done = i.done;
  endtask

  task automatic check(input logic [7:0] exp, input string nm);
    n_vec++;
    if (outs !== exp) begin
      n_bad++;
      $display("FAIL %s: outputs %b, required %b", nm, outs, exp);
    end
  endtask

  task automatic cyc(input in_t i, input logic [7:0] exp, input string nm);
    apply(i);
    @(negedge clk);
    check(exp, nm);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    apply('0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Reference model: count of in-flight writes per register plus MDU wait flag.
  int pend[32];
  bit in_mdu, merr;
  int tmo;

  function automatic logic [7:0] model_out(input in_t i);
    logic [7:0] e;
    bit haz;
    haz = i.iv && ((i.rs1 != 0 && pend[i.rs1] > 0) || (i.rs2 != 0 && pend[i.rs2] > 0) ||
                   (i.rw && i.rd != 0 && pend[i.rd] == 3));
    e = OK;
    if (in_mdu)            e = WT;
    else if (i.redir)      e = FL;
    else if (haz)          e = HAZ;
    else if (i.iv && i.mop) e = ST;
    e[0] = merr;
    return e;
  endfunction

  function automatic void model_step(input in_t i);
    bit haz, iss;
    haz = i.iv && ((i.rs1 != 0 && pend[i.rs1] > 0) || (i.rs2 != 0 && pend[i.rs2] > 0) ||
                   (i.rw && i.rd != 0 && pend[i.rd] == 3));
    iss = i.iv && !in_mdu && !haz && !i.redir;
    if (i.wv && i.rwwb && i.rdwb != 0) begin
      if (pend[i.rdwb] == 0) merr = 1'b1;
      else pend[i.rdwb]--;
    end
    if (iss && i.rw && i.rd != 0) pend[i.rd]++;
    if (in_mdu) begin
      if (i.done) begin in_mdu = 1'b0; tmo = 0; end
      else begin tmo++; if (tmo == 64) merr = 1'b1; end
    end else begin
      if (i.done) merr = 1'b1;
      if (iss && i.mop) in_mdu = 1'b1;
    end
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    in_t r;
    rst = 1'b1;
    apply(mk(1, 5, 6, 7, 1, 1, 1, 3, 1));
    @(negedge clk);
    check(OK, "outs_in_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    cyc('0, OK, "post_reset_idle");

    add(mk(1,1,2,5,1,0,0,N,0), OK,  "issue_x5");
    add(mk(1,5,0,6,1,0,0,N,0), HAZ, "raw_x5");
    add(mk(1,5,0,6,1,0,0,5,0), HAZ, "raw_x5_same_retire");
    add(mk(1,5,0,6,1,0,0,N,0), OK,  "raw_x5_released");
    add(mk(1,0,0,7,1,0,0,N,0), OK,  "x7_w1");
    add(mk(1,0,0,7,1,0,0,N,0), OK,  "x7_w2");
    add(mk(1,0,0,7,1,0,0,N,0), OK,  "x7_w3");
    add(mk(1,0,0,7,1,0,0,N,0), HAZ, "x7_full");
    add(mk(1,0,0,7,1,0,0,6,0), HAZ, "x7_full_other_retire");
    add(mk(1,0,0,7,1,0,0,7,0), HAZ, "x7_full_same_retire");
    add(mk(1,0,0,7,1,0,0,N,0), OK,  "x7_w4");
    add(mk(1,0,0,0,1,0,0,N,0), OK,  "x0_writer");
    add(mk(1,0,0,9,1,0,0,N,0), OK,  "x9_w1");
    add(mk(1,0,0,9,1,0,0,9,0), OK,  "x9_inc_dec");
    add(mk(1,9,0,0,0,0,0,9,0), HAZ, "x9_reader_stall");
    add(mk(1,9,0,0,0,0,0,N,0), OK,  "x9_reader_issue");
    add(mk(1,7,0,0,0,0,1,N,0), FL,  "redirect_hazard");
    add(mk(1,0,0,1,1,0,1,N,0), FL,  "redirect_writer");
    add(mk(1,1,0,0,0,0,0,N,0), OK,  "redirect_no_count");
    add(mk(0,0,0,0,0,0,0,7,0), OK,  "x7_drain1");
    add(mk(0,0,0,0,0,0,0,7,0), OK,  "x7_drain2");
    add(mk(0,0,0,0,0,0,0,7,0), OK,  "x7_drain3");
    add(mk(1,7,7,0,0,0,0,N,0), OK,  "x7_free");
    add(mk(1,1,2,3,1,1,0,N,0), ST,  "mdu_start");
    add(mk(1,1,0,2,1,0,0,N,0), WT,  "mdu_wait1");
    add(mk(1,1,0,2,1,0,1,N,0), WT,  "mdu_wait_redirect");
    add(mk(1,1,0,2,1,0,0,3,0), WT,  "mdu_wait_retire");
    add(mk(1,1,0,2,1,0,0,N,0), WT,  "mdu_wait4");
    add(mk(1,1,0,2,1,0,0,N,1), WT,  "mdu_done_cycle");
    add(mk(1,3,0,2,1,0,0,N,0), OK,  "mdu_resume");
    add(mk(0,0,0,0,0,0,0,4,0), OK,  "underflow_x4");
    add('0, ER, "err_set");
    add('0, ER, "err_sticky");
    foreach (tbl[k]) cyc(tbl[k].i, tbl[k].exp, tbl[k].nm);

    do_reset();
    cyc('0, OK, "rst_clears_err");
    cyc(mk(1,2,0,0,0,0,0,N,0), OK, "rst_clears_cnt");

    cyc(mk(0,0,0,0,0,0,0,N,1), OK, "done_in_run");
    cyc('0, ER, "done_in_run_err");

    do_reset();
    cyc(mk(1,0,0,0,0,1,0,N,0), ST, "tmo_start");
    for (int k = 1; k <= 64; k++) cyc('0, WT, "tmo_wait");
    cyc('0, WT | ER, "tmo_err");
    cyc(mk(0,0,0,0,0,0,0,N,1), WT | ER, "tmo_done");
    cyc('0, ER, "tmo_back_run");

    do_reset();
    cyc(mk(1,0,0,8,1,1,0,N,0), ST, "mid_mdu_start");
    cyc('0, WT, "mid_mdu_wait");
    rst = 1'b1;
    apply(mk(1,8,0,0,0,0,1,N,0));
    @(negedge clk);
    check(OK, "mid_mdu_reset_outs");
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(mk(1,8,0,8,1,1,0,N,0), ST, "mid_mdu_restart");

    do_reset();
    foreach (pend[k]) pend[k] = 0;
    in_mdu = 1'b0; merr = 1'b0; tmo = 0;
    for (int c = 0; c < 2000; c++) begin
      int w;
      r       = '0;
      r.iv    = ($urandom_range(3) != 0);
      r.rs1   = 5'($urandom_range(7));
      r.rs2   = 5'($urandom_range(7));
      r.rd    = 5'($urandom_range(7));
      r.rw    = ($urandom_range(3) != 0);
      r.mop   = ($urandom_range(7) == 0);
      r.redir = ($urandom_range(9) == 0);
      w = $urandom_range(1, 7);
      if (pend[w] > 0 && $urandom_range(1) == 1) begin
        r.wv = 1'b1; r.rwwb = 1'b1; r.rdwb = 5'(w);
      end else if ($urandom_range(3) == 0) begin
        r.wv = 1'b1; r.rwwb = ($urandom_range(1) == 1); r.rdwb = r.rwwb ? 5'd0 : 5'(w);
      end
      r.done = in_mdu && ($urandom_range(3) == 0);
      apply(r);
      @(negedge clk);
      check(model_out(r), "random");
      model_step(r);
      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/scoreboard_ctrl.md
Name: scoreboard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RISC-V core; replaces pure comparator-based RAW detection with a per-register pending-write scoreboard.
- Generates stall/flush/bubble controls for the IF, ID and EX stages.
- Sequences the multi-cycle multiply/divide unit (MDU) through a start/done handshake.
- Sits beside the ID stage; observes ID issue, EX redirect and WB retire.

Parameters:
- NREGS, 32, number of architectural registers; x0 is never tracked.
- CNT_W, 2, width of each pending-write counter (max in-flight writes per register = 2^CNT_W-1).
- MDU_TIMEOUT, 64, cycles in MDU_WAIT before sb_err is raised.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- id_valid  in  1  valid instruction in ID
- rs1_id  in  5  source register 1 in ID
- rs2_id  in  5  source register 2 in ID
- rd_id  in  5  destination register in ID
- regwrite_id  in  1  ID instruction writes rd
- mdu_op_id  in  1  ID instruction is an MDU op
- redirect_ex  in  1  taken branch/jump mispredict resolved in EX
- wb_valid  in  1  valid instruction in WB
- rd_wb  in  5  WB destination register
- regwrite_wb  in  1  WB writes rd
- mdu_done  in  1  MDU result ready (1-cycle pulse)
- stall_if  out  1  hold PC and IF/ID register
- stall_id  out  1  hold ID
- bubble_ex  out  1  load NOP into ID/EX
- stall_ex  out  1  hold ID/EX and EX
- flush_if  out  1  kill IF/ID contents
- flush_id  out  1  kill ID/EX input (same as bubble, from redirect)
- mdu_start  out  1  start MDU (1-cycle pulse)
- sb_err  out  1  sticky scoreboard/protocol error

Behaviour:
- Reset: all counters 0, state RUN, timeout counter 0, sb_err 0. While rst is high, all outputs are 0.
- Hazard:
  - hazard = id_valid && ((rs1_id!=0 && cnt[rs1_id]!=0) || (rs2_id!=0 && cnt[rs2_id]!=0) || (regwrite_id && rd_id!=0 && cnt[rd_id]==max)).
  - Uses stored counts only: a same-cycle WB retire does not release the hazard. Release occurs the cycle after retire, because the regfile is not write-through.
- Issue:
  - issue = id_valid && state==RUN && !hazard && !redirect_ex.
  - On issue with regwrite_id && rd_id!=0: cnt[rd_id]++.
- Retire: wb_valid && regwrite_wb && rd_wb!=0 gives cnt[rd_wb]--.
  - Decrement at 0: count stays 0 and sb_err is set.
- Same-cycle increment and decrement on the same register leaves the count unchanged.
- x0 counter is hardwired to 0.
- FSM states:
  - RUN:
    - redirect_ex=1 (highest priority): flush_if=1, flush_id=1; no issue this cycle; stay RUN.
    - Else hazard=1: stall_if=1, stall_id=1, bubble_ex=1.
    - Else issue && mdu_op_id: mdu_start=1 for exactly one cycle; counter increment as normal; next state MDU_WAIT.
    - mdu_done in RUN is ignored and sets sb_err.
  - MDU_WAIT:
    - stall_if=stall_id=stall_ex=1; MEM/WB drain freely, so retires still decrement.
    - mdu_start=0; timeout counter increments.
    - mdu_done=1: go to RUN and clear the timeout counter. Outputs stall for that cycle; the next instruction issues in the following cycle at the earliest.
    - Timeout counter reaching MDU_TIMEOUT: set sb_err; remain in MDU_WAIT.
    - redirect_ex is ignored here, since EX holds the MDU op.
- Minimum MDU latency is 1: mdu_done may arrive the cycle after mdu_start.
- Outputs are combinational from registered state plus current inputs; no extra latency.
- Reset asserted mid-MDU: FSM returns to RUN and counters clear; the MDU is reset by the same rst.

Decomposition:
- Shared package: FSM state encoding (ST_RUN, ST_MDU_WAIT), REG_X0 constant, CNT_W default.
- One sub-module, sb_counter_bank: NREGS×CNT_W saturating up/down counter array with one increment port, one decrement port, two read ports plus a full flag.

Test Plan:
- Back-to-back RAW: issue add x5 (regwrite), next ID reads x5 -> stall_if/stall_id/bubble_ex=1 until the cycle after WB retire of x5, then issue.
- Triple write x7 with no reader: cnt[7] reaches 3; a fourth x7 writer in ID -> stall until one retire; x0 writer never stalls or counts.
- Same-cycle issue and retire on x9 with cnt=1 -> cnt stays 1; a reader of x9 in that cycle still stalls.
- MDU: issue mul x3 -> mdu_start pulse one cycle, MDU_WAIT with stall_ex=1; mdu_done after 5 cycles -> RUN next cycle, stalls drop.
- redirect_ex together with a hazard in ID -> flush_if=flush_id=1, bubble_ex=0, no counter change; redirect during MDU_WAIT -> ignored.
- Errors: retire of x4 with cnt=0 -> sb_err=1 and sticky; no mdu_done for 64 cycles -> sb_err=1; rst clears all.
